hssdrc_sys_req_buffer: RTL and testbench

//  Upstream master of the HSSDRC system interface. Queues user requests (write/read/refresh) and write data,
//  and drives write/read/refr + rowa/cola/ba/burst/chid_i + wdata/wdatam into the controller under its

---
 rtl/hssdrc_sys_req_buffer_pkg.sv | 40 ++++
 rtl/hssdrc_sys_req_buffer_if.sv | 33 +++
 rtl/hssdrc_sys_req_buffer_sync_fifo.sv | 57 +++++
 rtl/hssdrc_sys_req_buffer.sv | 144 ++++++++++++++
 tb/tb_hssdrc_sys_req_buffer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hssdrc_sys_req_buffer_pkg.sv
// Shared types for the HSSDRC system-side request buffer.
//  - request field types (row/column/bank/burst/channel id, data word and mask)
//  - sys_cmd_e : 2-bit command encoding on the user and controller sides
//  - ocr_state_e : occupancy of the output command register
//  - cmd_pkt_t : one command FIFO entry
package hssdrc_sys_req_buffer_pkg;

   typedef logic [11:0] rowa_t;
   typedef logic [9:0]  cola_t;
   typedef logic [1:0]  ba_t;
   typedef logic [1:0]  burst_t;   // burst length minus one
   typedef logic [3:0]  chid_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  datam_t;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2,
      CMD_REFR  = 2'd3
   } sys_cmd_e;

   typedef enum logic {
      OcrEmpty  = 1'b0,
      OcrLoaded = 1'b1
   } ocr_state_e;

   typedef struct packed {
      sys_cmd_e cmd;
      rowa_t    rowa;
      cola_t    cola;
      ba_t      ba;
      burst_t   burst;
      chid_t    chid;
   } cmd_pkt_t;

   localparam int unsigned CmdPktWidth = $bits(cmd_pkt_t);
   localparam int unsigned WordWidth   = $bits(datam_t) + $bits(data_t);

endpackage

// File: rtl/hssdrc_sys_req_buffer_if.sv
// Controller-side bus of the request buffer.
//  master : command strobes + fields, write data, takes ready/use_wdata and read returns
//  slave  : the controller view of the same signals
interface hssdrc_sys_req_buffer_if;
   import hssdrc_sys_req_buffer_pkg::*;

   logic   write;
   logic   read;
   logic   refr;
   rowa_t  rowa;
   cola_t  cola;
   ba_t    ba;
   burst_t burst;
   chid_t  chid_i;
   logic   ready;
   logic   use_wdata;
   data_t  wdata;
   datam_t wdatam;
   logic   vld_rdata;
   chid_t  chid_o;
   data_t  rdata;

   modport master (
      output write, read, refr, rowa, cola, ba, burst, chid_i, wdata, wdatam,
      input  ready, use_wdata, vld_rdata, chid_o, rdata
   );

   modport slave (
      input  write, read, refr, rowa, cola, ba, burst, chid_i, wdata, wdatam,
      output ready, use_wdata, vld_rdata, chid_o, rdata
   );

endinterface

// File: rtl/hssdrc_sys_req_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO (hssdrc_sync_fifo).
//  push/din : write a word when not full, or when full and popping in the same cycle
//  pop/dout : dout is the head word; pop is ignored when empty
//  full/empty/count : occupancy status
//  reset    : synchronous, active-low; clears pointers and occupancy
module hssdrc_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din;
   end

   assign dout  = mem_q[rptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/hssdrc_sys_req_buffer.sv
// HSSDRC system-interface request buffer (upstream master of the controller).
//  clk, reset             : clock, synchronous active-low reset
//  req_*                  : user command push (valid/ready) with request fields
//  wd_*                   : user write-data push (valid/ready), word + mask
//  sys (master modport)   : command strobes/fields, write data, ready/use_wdata, read return
//  rd_valid/rd_chid/rd_data : read return registered one cycle
//  err_underflow          : sticky, controller consumed a word while none was buffered
// A WRITE leaves only once its whole burst is buffered and not already promised to an
// earlier WRITE; the promised words are tracked in reserved_q.
module hssdrc_sys_req_buffer
   import hssdrc_sys_req_buffer_pkg::*;
#(
   parameter int unsigned CMD_DEPTH   = 4,
   parameter int unsigned WDATA_DEPTH = 16
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     req_valid,
   output logic     req_ready,
   input  sys_cmd_e req_cmd,
   input  rowa_t    req_rowa,
   input  cola_t    req_cola,
   input  ba_t      req_ba,
   input  burst_t   req_burst,
   input  chid_t    req_chid,
   input  logic     wd_valid,
   output logic     wd_ready,
   input  data_t    wd_data,
   input  datam_t   wd_datam,
   hssdrc_sys_req_buffer_if.master sys,
   output logic     rd_valid,
   output chid_t    rd_chid,
   output data_t    rd_data,
   output logic     err_underflow
);

   localparam int unsigned CCW = $clog2(CMD_DEPTH) + 1;
   localparam int unsigned WCW = $clog2(WDATA_DEPTH) + 1;

   cmd_pkt_t                 cmd_in, cmd_head, ocr_q;
   logic [CmdPktWidth-1:0]   cmd_dout;
   logic                     cmd_full, cmd_empty, cmd_pop;
   logic [CCW-1:0]           cmd_count;
   logic [WordWidth-1:0]     wd_dout;
   logic                     wd_full, wd_empty, wd_pop;
   logic [WCW-1:0]           wd_count, reserved_q, reserved_d, need, avail;
   logic                     head_elig, ocr_free, load, err_q;
   ocr_state_e               state_q, state_d;

   assign cmd_in = '{cmd: req_cmd, rowa: req_rowa, cola: req_cola, ba: req_ba,
                     burst: req_burst, chid: req_chid};

   hssdrc_sync_fifo #(.WIDTH(CmdPktWidth), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid),
      .din   (cmd_in),
      .pop   (cmd_pop),
      .dout  (cmd_dout),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (cmd_count)
   );

   hssdrc_sync_fifo #(.WIDTH(WordWidth), .DEPTH(WDATA_DEPTH)) u_wd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wd_valid),
      .din   ({wd_datam, wd_data}),
      .pop   (sys.use_wdata),
      .dout  (wd_dout),
      .full  (wd_full),
      .empty (wd_empty),
      .count (wd_count)
   );

   assign cmd_head = cmd_pkt_t'(cmd_dout);
   assign wd_pop   = sys.use_wdata & ~wd_empty;

   // Words buffered but not yet promised to an issued WRITE.
   assign need      = WCW'(cmd_head.burst) + WCW'(1);
   assign avail     = wd_count - reserved_q;
   assign head_elig = ~cmd_empty & ((cmd_head.cmd != CMD_WRITE) || (avail >= need));

   // A freed slot lets the user push even when the FIFO is full this cycle.
   assign req_ready = ~cmd_full | cmd_pop;
   assign wd_ready  = ~wd_full | wd_pop;

   always_comb begin
      state_d  = state_q;
      cmd_pop  = 1'b0;
      load     = 1'b0;
      ocr_free = (state_q == OcrEmpty) | sys.ready;
      if (ocr_free) begin
         cmd_pop = head_elig;
         // CMD_NONE is popped but never presented to the controller.
         load    = head_elig & (cmd_head.cmd != CMD_NONE);
         state_d = load ? OcrLoaded : OcrEmpty;
      end
   end

   always_comb begin
      reserved_d = reserved_q;
      if (load && (cmd_head.cmd == CMD_WRITE)) reserved_d = reserved_d + need;
      if (wd_pop && (reserved_d != '0))        reserved_d = reserved_d - WCW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= OcrEmpty;
         ocr_q      <= '0;
         reserved_q <= '0;
         err_q      <= 1'b0;
         rd_valid   <= 1'b0;
         rd_chid    <= '0;
         rd_data    <= '0;
      end else begin
         state_q    <= state_d;
         if (load) ocr_q <= cmd_head;
         reserved_q <= reserved_d;
         if (sys.use_wdata && wd_empty) err_q <= 1'b1;
         rd_valid   <= sys.vld_rdata;
         rd_chid    <= sys.chid_o;
         rd_data    <= sys.rdata;
      end
   end

   assign sys.write  = (state_q == OcrLoaded) && (ocr_q.cmd == CMD_WRITE);
   assign sys.read   = (state_q == OcrLoaded) && (ocr_q.cmd == CMD_READ);
   assign sys.refr   = (state_q == OcrLoaded) && (ocr_q.cmd == CMD_REFR);
   assign sys.rowa   = ocr_q.rowa;
   assign sys.cola   = ocr_q.cola;
   assign sys.ba     = ocr_q.ba;
   assign sys.burst  = ocr_q.burst;
   assign sys.chid_i = ocr_q.chid;
   assign {sys.wdatam, sys.wdata} = wd_empty ? '0 : wd_dout;
   assign err_underflow = err_q;

   a_cmd_count: assert property (@(posedge clk) disable iff (!reset)
      cmd_count <= CCW'(CMD_DEPTH));
   a_reserved: assert property (@(posedge clk) disable iff (!reset)
      reserved_q <= WCW'(WDATA_DEPTH));

endmodule

// File: tb/tb_hssdrc_sys_req_buffer.sv
module tb_hssdrc_sys_req_buffer;
   import hssdrc_sys_req_buffer_pkg::*;

   localparam int unsigned CmdDepth = 4;
   localparam int unsigned WdDepth  = 16;

   logic     clk = 1'b0;
   logic     reset;
   logic     req_valid, req_ready, wd_valid, wd_ready;
   sys_cmd_e req_cmd;
   rowa_t    req_rowa;
   cola_t    req_cola;
   ba_t      req_ba;
   burst_t   req_burst;
   chid_t    req_chid;
   data_t    wd_data;
   datam_t   wd_datam;
   logic     rd_valid, err_underflow;
   chid_t    rd_chid;
   data_t    rd_data;

   int vec  = 0;
   int errs = 0;

   hssdrc_sys_req_buffer_if sys_if ();

   hssdrc_sys_req_buffer #(.CMD_DEPTH(CmdDepth), .WDATA_DEPTH(WdDepth)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_cmd       (req_cmd),
      .req_rowa      (req_rowa),
      .req_cola      (req_cola),
      .req_ba        (req_ba),
      .req_burst     (req_burst),
      .req_chid      (req_chid),
      .wd_valid      (wd_valid),
      .wd_ready      (wd_ready),
      .wd_data       (wd_data),
      .wd_datam      (wd_datam),
      .sys           (sys_if),
      .rd_valid      (rd_valid),
      .rd_chid       (rd_chid),
      .rd_data       (rd_data),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_req(input logic v, input sys_cmd_e c, input rowa_t r, input cola_t co,
                            input ba_t b, input burst_t bu, input chid_t ch);
      req_valid = v; req_cmd = c; req_rowa = r; req_cola = co;
      req_ba = b; req_burst = bu; req_chid = ch;
   endtask

   task automatic drive_idle();
      drive_req(1'b0, CMD_NONE, '0, '0, '0, '0, '0);
   endtask

   task automatic drive_wd(input logic v, input data_t d, input datam_t m);
      wd_valid = v; wd_data = d; wd_datam = m;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive_req(1'b1, CMD_READ, 12'h111, 10'h222, 2'd3, 2'd1, 4'd6);
      drive_wd(1'b1, 32'hFFFF_FFFF, 4'hF);
      sys_if.ready = 1'b1; sys_if.use_wdata = 1'b1;
      sys_if.vld_rdata = 1'b1; sys_if.chid_o = 4'hF; sys_if.rdata = 32'h1234_5678;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         vec++;
         if ({sys_if.write, sys_if.read, sys_if.refr, rd_valid, err_underflow} !== 5'b0) begin
            errs++;
            $display("FAIL reset_outputs: got w/r/f/rdv/err=%b want 00000",
                     {sys_if.write, sys_if.read, sys_if.refr, rd_valid, err_underflow});
         end
         vec++;
         if ({req_ready, wd_ready} !== 2'b11) begin
            errs++; $display("FAIL reset_ready: got %b want 11", {req_ready, wd_ready});
         end
         step();
      end
      drive_idle(); drive_wd(1'b0, '0, '0);
      sys_if.ready = 1'b0; sys_if.use_wdata = 1'b0; sys_if.vld_rdata = 1'b0;
      reset = 1'b1;
      step(); step(); step();
      vec++;
      if (sys_if.read !== 1'b0) begin
         errs++; $display("FAIL reset_no_capture: read=%b want 0", sys_if.read);
      end
      vec++;
      if ({sys_if.rowa, sys_if.cola, sys_if.ba, sys_if.burst, sys_if.chid_i,
           sys_if.wdatam, sys_if.wdata} !== '0) begin
         errs++; $display("FAIL reset_fields: rowa=%h chid=%h wdata=%h want 0",
                          sys_if.rowa, sys_if.chid_i, sys_if.wdata);
      end
   endtask

   task automatic test_read();
      sys_if.ready = 1'b1;
      drive_req(1'b1, CMD_READ, 12'h012, 10'h034, 2'd1, 2'd0, 4'd3);
      step();
      drive_idle();
      vec++;
      if (sys_if.read !== 1'b0) begin
         errs++; $display("FAIL read_early: read=%b want 0", sys_if.read);
      end
      step();
      vec++;
      if ({sys_if.write, sys_if.read, sys_if.refr} !== 3'b010) begin
         errs++; $display("FAIL read_strobe: w/r/f=%b want 010",
                          {sys_if.write, sys_if.read, sys_if.refr});
      end
      vec++;
      if ({sys_if.rowa, sys_if.cola, sys_if.ba, sys_if.chid_i} !==
          {12'h012, 10'h034, 2'd1, 4'd3}) begin
         errs++; $display("FAIL read_fields: rowa=%h cola=%h ba=%0d chid=%0d want 012 034 1 3",
                          sys_if.rowa, sys_if.cola, sys_if.ba, sys_if.chid_i);
      end
      step();
      vec++;
      if (sys_if.read !== 1'b0) begin
         errs++; $display("FAIL read_width: read=%b want 0", sys_if.read);
      end
      // CMD_NONE is dropped; the READ behind it still leaves.
      drive_req(1'b1, CMD_NONE, 12'h7FF, '0, '0, '0, 4'd8);
      step();
      drive_req(1'b1, CMD_READ, 12'h044, 10'h055, 2'd0, 2'd0, 4'd4);
      step();
      drive_idle();
      vec++;
      if ({sys_if.write, sys_if.read, sys_if.refr} !== 3'b000) begin
         errs++; $display("FAIL none_dropped: w/r/f=%b want 000",
                          {sys_if.write, sys_if.read, sys_if.refr});
      end
      step();
      vec++;
      if ({sys_if.read, sys_if.chid_i} !== {1'b1, 4'd4}) begin
         errs++; $display("FAIL read_after_none: read=%b chid=%0d want 1 4",
                          sys_if.read, sys_if.chid_i);
      end
      step();
   endtask

   task automatic test_write_gating();
      data_t  w [4];
      datam_t m [4];
      for (int i = 0; i < 4; i++) begin
         w[i] = 32'h1000_0000 + 32'(i);
         m[i] = 4'hF - 4'(i);
      end
      sys_if.ready = 1'b1;
      drive_req(1'b1, CMD_WRITE, 12'h055, 10'h010, 2'd2, 2'd3, 4'd1);
      drive_wd(1'b1, w[0], m[0]);
      step();
      drive_idle(); drive_wd(1'b1, w[1], m[1]);
      step();
      drive_wd(1'b0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (sys_if.write !== 1'b0) begin
            errs++; $display("FAIL write_gated: write=%b want 0 (cycle %0d)", sys_if.write, i);
         end
         step();
      end
      drive_wd(1'b1, w[2], m[2]); step();
      drive_wd(1'b1, w[3], m[3]); step();
      drive_wd(1'b0, '0, '0);
      vec++;
      if (sys_if.write !== 1'b0) begin
         errs++; $display("FAIL write_early: write=%b want 0", sys_if.write);
      end
      step();
      vec++;
      if ({sys_if.write, sys_if.rowa, sys_if.cola, sys_if.ba, sys_if.burst, sys_if.chid_i} !==
          {1'b1, 12'h055, 10'h010, 2'd2, 2'd3, 4'd1}) begin
         errs++; $display("FAIL write_issue: write=%b rowa=%h cola=%h ba=%0d burst=%0d chid=%0d",
                          sys_if.write, sys_if.rowa, sys_if.cola, sys_if.ba, sys_if.burst,
                          sys_if.chid_i);
      end
      step();
      vec++;
      if (sys_if.write !== 1'b0) begin
         errs++; $display("FAIL write_width: write=%b want 0", sys_if.write);
      end
      for (int i = 0; i < 4; i++) begin
         vec++;
         if ({sys_if.wdatam, sys_if.wdata} !== {m[i], w[i]}) begin
            errs++; $display("FAIL wdata_order: word %0d got %h/%h want %h/%h", i,
                             sys_if.wdatam, sys_if.wdata, m[i], w[i]);
         end
         sys_if.use_wdata = 1'b1;
         step();
         sys_if.use_wdata = 1'b0;
      end
      vec++;
      if ({sys_if.wdatam, sys_if.wdata} !== '0) begin
         errs++; $display("FAIL wdata_empty: got %h/%h want 0", sys_if.wdatam, sys_if.wdata);
      end
      // Leftover reservation would block this fully-buffered WRITE.
      for (int i = 0; i < 4; i++) begin
         drive_wd(1'b1, w[i] ^ 32'hFFFF_0000, m[i]);
         step();
      end
      drive_wd(1'b0, '0, '0);
      drive_req(1'b1, CMD_WRITE, 12'h0AA, 10'h020, 2'd0, 2'd3, 4'd9);
      step();
      drive_idle();
      step();
      vec++;
      if ({sys_if.write, sys_if.chid_i} !== {1'b1, 4'd9}) begin
         errs++; $display("FAIL reserved_release: write=%b chid=%0d want 1 9",
                          sys_if.write, sys_if.chid_i);
      end
      step();
      sys_if.use_wdata = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (sys_if.wdata !== (w[i] ^ 32'hFFFF_0000)) begin
            errs++; $display("FAIL wdata_b2b: word %0d got %h want %h", i, sys_if.wdata,
                             w[i] ^ 32'hFFFF_0000);
         end
         step();
      end
      sys_if.use_wdata = 1'b0;
      vec++;
      if ({sys_if.wdata, err_underflow} !== '0) begin
         errs++; $display("FAIL drain_clean: wdata=%h err=%b want 0 0", sys_if.wdata,
                          err_underflow);
      end
   endtask

   task automatic test_hold();
      sys_if.ready = 1'b0;
      drive_req(1'b1, CMD_REFR, 12'hABC, 10'h1FF, 2'd3, 2'd0, 4'd7);
      step();
      drive_req(1'b1, CMD_READ, 12'h001, 10'h002, 2'd0, 2'd0, 4'd2);
      step();
      drive_idle();
      for (int i = 0; i < 6; i++) begin
         vec++;
         if ({sys_if.write, sys_if.read, sys_if.refr, sys_if.rowa, sys_if.cola, sys_if.ba,
              sys_if.chid_i} !== {3'b001, 12'hABC, 10'h1FF, 2'd3, 4'd7}) begin
            errs++; $display("FAIL hold_stable: cycle %0d w/r/f=%b rowa=%h chid=%0d", i,
                             {sys_if.write, sys_if.read, sys_if.refr}, sys_if.rowa,
                             sys_if.chid_i);
         end
         step();
      end
      sys_if.ready = 1'b1;
      step();
      vec++;
      if ({sys_if.write, sys_if.read, sys_if.refr, sys_if.rowa, sys_if.chid_i} !==
          {3'b010, 12'h001, 4'd2}) begin
         errs++; $display("FAIL hold_next: w/r/f=%b rowa=%h chid=%0d want 010 001 2",
                          {sys_if.write, sys_if.read, sys_if.refr}, sys_if.rowa, sys_if.chid_i);
      end
      step();
      vec++;
      if ({sys_if.write, sys_if.read, sys_if.refr} !== 3'b000) begin
         errs++; $display("FAIL hold_drain: w/r/f=%b want 000",
                          {sys_if.write, sys_if.read, sys_if.refr});
      end
   endtask

   task automatic test_full();
      sys_if.ready = 1'b0;
      // First command moves into the output register, the next CmdDepth fill the FIFO.
      for (int c = 0; c <= CmdDepth; c++) begin
         vec++;
         if (req_ready !== 1'b1) begin
            errs++; $display("FAIL req_ready_filling: push %0d req_ready=%b want 1", c, req_ready);
         end
         drive_req(1'b1, CMD_READ, 12'(c), '0, '0, '0, 4'(c));
         step();
      end
      drive_idle();
      vec++;
      if ({req_ready, sys_if.read, sys_if.chid_i} !== {1'b0, 1'b1, 4'd0}) begin
         errs++; $display("FAIL full_state: req_ready=%b read=%b chid=%0d want 0 1 0",
                          req_ready, sys_if.read, sys_if.chid_i);
      end
      drive_req(1'b1, CMD_READ, 12'h0FF, '0, '0, '0, 4'd5);
      sys_if.ready = 1'b1;
      #1;
      vec++;
      if (req_ready !== 1'b1) begin
         errs++; $display("FAIL full_pop_push: req_ready=%b want 1", req_ready);
      end
      step();
      drive_idle();
      sys_if.ready = 1'b0;
      #1;
      vec++;
      if ({req_ready, sys_if.read, sys_if.chid_i} !== {1'b0, 1'b1, 4'd1}) begin
         errs++; $display("FAIL full_stays_full: req_ready=%b read=%b chid=%0d want 0 1 1",
                          req_ready, sys_if.read, sys_if.chid_i);
      end
      sys_if.ready = 1'b1;
      for (int e = 2; e <= 5; e++) begin
         step();
         vec++;
         if ({sys_if.read, sys_if.chid_i} !== {1'b1, 4'(e)}) begin
            errs++; $display("FAIL order: read=%b chid=%0d want 1 %0d", sys_if.read,
                             sys_if.chid_i, e);
         end
      end
      step();
      vec++;
      if (sys_if.read !== 1'b0) begin
         errs++; $display("FAIL full_drain: read=%b want 0", sys_if.read);
      end
   endtask

   task automatic test_underflow_read();
      sys_if.ready = 1'b0;
      vec++;
      if (err_underflow !== 1'b0) begin
         errs++; $display("FAIL underflow_pre: err=%b want 0", err_underflow);
      end
      sys_if.use_wdata = 1'b1;
      step();
      sys_if.use_wdata = 1'b0;
      vec++;
      if (err_underflow !== 1'b1) begin
         errs++; $display("FAIL underflow_set: err=%b want 1", err_underflow);
      end
      step(); step(); step();
      vec++;
      if (err_underflow !== 1'b1) begin
         errs++; $display("FAIL underflow_sticky: err=%b want 1", err_underflow);
      end
      sys_if.vld_rdata = 1'b1; sys_if.chid_o = 4'd5; sys_if.rdata = 32'h0000_A5A5;
      step();
      vec++;
      if ({rd_valid, rd_chid, rd_data} !== {1'b1, 4'd5, 32'h0000_A5A5}) begin
         errs++; $display("FAIL rd_path_1: got %b/%0d/%h want 1/5/0000a5a5", rd_valid, rd_chid,
                          rd_data);
      end
      sys_if.chid_o = 4'hF; sys_if.rdata = 32'hDEAD_BEEF;
      step();
      vec++;
      if ({rd_valid, rd_chid, rd_data} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin
         errs++; $display("FAIL rd_path_2: got %b/%0d/%h want 1/15/deadbeef", rd_valid, rd_chid,
                          rd_data);
      end
      sys_if.vld_rdata = 1'b0;
      step();
      vec++;
      if (rd_valid !== 1'b0) begin
         errs++; $display("FAIL rd_path_idle: rd_valid=%b want 0", rd_valid);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      vec++;
      if (err_underflow !== 1'b0) begin
         errs++; $display("FAIL underflow_reset: err=%b want 0", err_underflow);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_read();
      test_write_gating();
      test_hold();
      test_full();
      test_underflow_read();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
